// File: rtl/chirp_acq_ctrl_pkg.sv
// Shared definitions for the per-chirp acquisition sequencer: state encoding,
// default field widths and a small state classification helper.
package chirp_acq_ctrl_pkg;

    localparam int OW_DEF = 14;
    localparam int SW_DEF = 10;
    localparam int NW_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACQ    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_SETTLE) || (s == ST_ACQ);
    endfunction

endpackage

// File: rtl/chirp_acq_ctrl_cnt.sv
// Loadable down-counter with a terminal flag that is raised while one count
// remains, so the owner can act on the final decrement in the same cycle.
module chirp_acq_ctrl_cnt
    import chirp_acq_ctrl_pkg::*;
#(
    parameter int W = SW_DEF
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/chirp_acq_ctrl.sv
// Per-chirp sequencer: discards settling samples after ramp start, then frames
// exactly N decimated samples with valid/last and pulses done.
module chirp_acq_ctrl
    import chirp_acq_ctrl_pkg::*;
#(
    parameter int OW = OW_DEF,
    parameter int SW = SW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          arm_i,
    input  logic          cont_i,
    input  logic          chirp_start_i,
    input  logic [SW-1:0] settle_i,
    input  logic [NW-1:0] nsamp_i,
    input  logic          ds_valid_i,
    input  logic [OW-1:0] ds_data_i,
    output logic          ds_en_o,
    output logic          ds_clr_o,
    output logic [OW-1:0] data_o,
    output logic          valid_o,
    output logic          last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          overrun_o
);

    state_t state;
    logic   restart;
    logic   latch;
    logic   scnt_last;
    logic   ncnt_last;

    // A ramp start while a frame is in flight (or completing) abandons it.
    assign restart = chirp_start_i && (is_busy(state) || (state == ST_DONE));
    assign latch   = restart || (chirp_start_i && (state == ST_ARMED));

    chirp_acq_ctrl_cnt #(.W(SW)) u_settle_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load     (latch),
        .load_val (settle_i),
        .dec      (state == ST_SETTLE),
        .last     (scnt_last)
    );

    chirp_acq_ctrl_cnt #(.W(NW)) u_samp_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load     (latch),
        .load_val (nsamp_i),
        .dec      ((state == ST_ACQ) && ds_valid_i),
        .last     (ncnt_last)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            ds_en_o   <= 1'b0;
            ds_clr_o  <= 1'b0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            ds_clr_o <= 1'b0;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            done_o   <= 1'b0;

            if (restart) begin
                overrun_o <= 1'b1;
            end else if (arm_i) begin
                overrun_o <= 1'b0;
            end

            if (latch) begin
                if (nsamp_i == '0) begin
                    state   <= ST_DONE;
                    ds_en_o <= 1'b0;
                    busy_o  <= 1'b0;
                end else if (settle_i == '0) begin
                    state    <= ST_ACQ;
                    ds_en_o  <= 1'b1;
                    ds_clr_o <= 1'b1;
                    busy_o   <= 1'b1;
                end else begin
                    state   <= ST_SETTLE;
                    ds_en_o <= 1'b0;
                    busy_o  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm_i) state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                    end
                    ST_SETTLE: begin
                        if (scnt_last) begin
                            state    <= ST_ACQ;
                            ds_en_o  <= 1'b1;
                            ds_clr_o <= 1'b1;
                        end
                    end
                    ST_ACQ: begin
                        if (ds_valid_i) begin
                            data_o  <= ds_data_i;
                            valid_o <= 1'b1;
                            if (ncnt_last) begin
                                last_o  <= 1'b1;
                                state   <= ST_DONE;
                                ds_en_o <= 1'b0;
                                busy_o  <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        done_o <= 1'b1;
                        state  <= cont_i ? ST_ARMED : ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chirp_acq_ctrl.sv
// Directed bench for chirp_acq_ctrl: a decimate-by-4 downsampler model feeds a
// ramp and queues each sample's expected data/last for the output monitor.
module tb_chirp_acq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        arm_i = 1'b0;
    logic        cont_i = 1'b0;
    logic        chirp_start_i = 1'b0;
    logic [9:0]  settle_i = '0;
    logic [11:0] nsamp_i = '0;
    logic        ds_valid_i = 1'b0;
    logic [13:0] ds_data_i = '0;
    logic        ds_en_o;
    logic        ds_clr_o;
    logic [13:0] data_o;
    logic        valid_o;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;

    typedef struct packed {
        logic [13:0] d;
        logic        l;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int  n_checks = 0;
    int  n_pass = 0;
    int  n_valid = 0;
    int  n_last = 0;
    int  n_done = 0;
    int  n_clr = 0;
    int  cur_n = 0;
    int  acc = 0;
    int  ph = 0;
    int  v0, l0, d0, c0;
    time t_last = 0;
    time t_done = 0;

    chirp_acq_ctrl dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .arm_i         (arm_i),
        .cont_i        (cont_i),
        .chirp_start_i (chirp_start_i),
        .settle_i      (settle_i),
        .nsamp_i       (nsamp_i),
        .ds_valid_i    (ds_valid_i),
        .ds_data_i     (ds_data_i),
        .ds_en_o       (ds_en_o),
        .ds_clr_o      (ds_clr_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_chirp(input int n);
        cur_n = n;
        acc = 0;
        chirp_start_i = 1'b1;
        tick();
        chirp_start_i = 1'b0;
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done_o && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(done_o), 1);
    endtask

    task automatic wait_valids(input string tag, input int base, input int n, input int budget);
        int k = 0;
        while ((n_valid - base) < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, n_valid - base, n);
    endtask

    // Downsampler model: one strobe every 4 enabled cycles, ramp data.
    always @(posedge clk_i) begin
        #1;
        ds_data_i = 14'(ds_data_i + 14'd1);
        if (!ds_en_o) begin
            ph = 0;
            ds_valid_i = 1'b0;
        end else begin
            ds_valid_i = (ph == 3);
            ph = (ph == 3) ? 0 : ph + 1;
            if (ds_valid_i) begin
                sb.push_back('{d: ds_data_i, l: (acc == cur_n - 1)});
                acc++;
            end
        end
    end

    always @(negedge clk_i) begin
        if (valid_o) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 1);
            end else begin
                e_mon = sb.pop_front();
                check("data", 32'(data_o), 32'(e_mon.d));
                check("last", 32'(last_o), 32'(e_mon.l));
            end
        end else if (last_o) begin
            check("last_without_valid", 32'(valid_o), 1);
        end
        if (last_o) begin
            n_last++;
            t_last = $time;
        end
        if (done_o) begin
            n_done++;
            t_done = $time;
        end
        if (ds_clr_o) n_clr++;
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_en", 32'(ds_en_o), 0);
        check("rst_clr", 32'(ds_clr_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_last", 32'(last_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_ovr", 32'(overrun_o), 0);
        rst_n_i = 1'b1;
        tick();

        // Basic single chirp
        cont_i = 1'b0;
        settle_i = 10'd5;
        nsamp_i = 12'd4;
        pulse_arm();
        v0 = n_valid; l0 = n_last; d0 = n_done; c0 = n_clr;
        start_chirp(4);
        check("basic_busy", 32'(busy_o), 1);
        repeat (4) tick();
        check("basic_en_early", 32'(ds_en_o), 0);
        tick();
        check("basic_en", 32'(ds_en_o), 1);
        check("basic_clr", 32'(ds_clr_o), 1);
        wait_done("basic_done", 200);
        tick();
        check("basic_done_pulse", 32'(done_o), 0);
        check("basic_busy_end", 32'(busy_o), 0);
        check("basic_nvalid", n_valid - v0, 4);
        check("basic_nlast", n_last - l0, 1);
        check("basic_nclr", n_clr - c0, 1);
        check("basic_done_gap", 32'(t_done - t_last), 10);
        start_chirp(4);
        repeat (10) tick();
        check("idle_ignores_chirp", 32'(busy_o), 0);
        check("idle_no_valid", n_valid - v0, 4);

        // Continuous mode, three chirps
        cont_i = 1'b1;
        nsamp_i = 12'd8;
        pulse_arm();
        v0 = n_valid; l0 = n_last; d0 = n_done;
        for (int i = 0; i < 3; i++) begin
            start_chirp(8);
            repeat (199) tick();
        end
        cont_i = 1'b0;
        check("cont_nvalid", n_valid - v0, 24);
        check("cont_nlast", n_last - l0, 3);
        check("cont_ndone", n_done - d0, 3);
        check("cont_ovr", 32'(overrun_o), 0);

        // Overrun: restart after 2 of 8 samples
        v0 = n_valid; l0 = n_last; d0 = n_done;
        start_chirp(8);
        wait_valids("ovr_first2", v0, 2, 200);
        start_chirp(8);
        check("ovr_set", 32'(overrun_o), 1);
        check("ovr_busy", 32'(busy_o), 1);
        wait_done("ovr_done", 300);
        tick();
        check("ovr_nvalid", n_valid - v0, 10);
        check("ovr_nlast", n_last - l0, 1);
        check("ovr_ndone", n_done - d0, 1);
        pulse_arm();
        check("ovr_cleared", 32'(overrun_o), 0);

        // settle=0, nsamp=1
        settle_i = 10'd0;
        nsamp_i = 12'd1;
        v0 = n_valid; l0 = n_last;
        start_chirp(1);
        check("s0_clr", 32'(ds_clr_o), 1);
        check("s0_en", 32'(ds_en_o), 1);
        wait_done("n1_done", 100);
        tick();
        check("n1_nvalid", n_valid - v0, 1);
        check("n1_nlast", n_last - l0, 1);

        // nsamp=0
        pulse_arm();
        nsamp_i = 12'd0;
        v0 = n_valid;
        start_chirp(0);
        check("n0_busy", 32'(busy_o), 0);
        check("n0_en", 32'(ds_en_o), 0);
        tick();
        check("n0_done", 32'(done_o), 1);
        tick();
        check("n0_nvalid", n_valid - v0, 0);

        // Reset mid-acquisition
        settle_i = 10'd3;
        nsamp_i = 12'd8;
        pulse_arm();
        v0 = n_valid;
        start_chirp(8);
        wait_valids("rst_first3", v0, 3, 200);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_en", 32'(ds_en_o), 0);
        check("arst_valid", 32'(valid_o), 0);
        check("arst_data", 32'(data_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_last", 32'(last_o), 0);
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        v0 = n_valid;
        start_chirp(8);
        repeat (40) tick();
        check("post_rst_busy", 32'(busy_o), 0);
        check("post_rst_en", 32'(ds_en_o), 0);
        check("post_rst_nvalid", n_valid - v0, 0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chirp_acq_ctrl.md
Name: chirp_acq_ctrl

Overview:
- Per-chirp sequencer for the downsample datapath in the FMCW receive chain.
- On each ramp-start pulse it does four things:
  - discards a programmable number of settling samples;
  - clears and enables the downsampler;
  - forwards exactly N decimated samples with valid/last framing;
  - then reports done.
- Sits between the ramp generator/ADC front end and the downstream sample buffer/FFT.

Parameters:
- OW, 14, sample width (downsampler output width).
- SW, 10, width of settle-count field (raw input cycles).
- NW, 12, width of output-sample-count field.

Ports:
- clk_i  in  1  system clock (raw ADC sample rate)
- rst_n_i  in  1  asynchronous active-low reset
- arm_i  in  1  pulse: IDLE→ARMED; also clears overrun_o
- cont_i  in  1  level: 1 = re-arm automatically after each chirp
- chirp_start_i  in  1  pulse: ramp start
- settle_i  in  SW  raw cycles to discard after chirp_start_i
- nsamp_i  in  NW  decimated samples per chirp
- ds_valid_i  in  1  downsampler output strobe
- ds_data_i  in  OW  downsampler output data
- ds_en_o  out  1  downsampler enable
- ds_clr_o  out  1  one-cycle downsampler phase/accumulator clear
- data_o  out  OW  framed sample
- valid_o  out  1  data_o qualifier
- last_o  out  1  marks final sample of chirp (with valid_o)
- busy_o  out  1  high in SETTLE or ACQ
- done_o  out  1  one-cycle pulse at chirp completion
- overrun_o  out  1  sticky: chirp_start_i arrived while busy

Behaviour:
- **Reset** (rst_n_i low, async): state=IDLE; all outputs 0, data_o=0, counters 0.
- **State machine**: IDLE, ARMED, SETTLE, ACQ, DONE.
  - IDLE: arm_i → ARMED. chirp_start_i is ignored.
  - ARMED: on chirp_start_i, latch settle_i→scnt and nsamp_i→nreg.
    - nsamp_i==0 → DONE.
    - else settle_i==0 → ACQ.
    - else → SETTLE.
  - SETTLE: scnt decrements every cycle. The transition to ACQ fires on the cycle scnt==1, so exactly settle_i cycles are spent in SETTLE.
  - ACQ:
    - Entry cycle: ds_clr_o=1. ds_en_o=1 for the whole state.
    - Each ds_valid_i: register ds_data_i→data_o, valid_o=1 next cycle (latency 1), increment ocnt.
    - When ocnt reaches nreg-1 on a ds_valid_i: last_o=1 with that sample, then → DONE.
  - DONE: done_o=1 for one cycle. Then → ARMED if cont_i else IDLE.
- **Output timing**: valid_o/last_o are single-cycle pulses. ds_en_o=0 outside ACQ. ds_valid_i outside ACQ is ignored.
- **Overrun**: chirp_start_i in SETTLE or ACQ sets overrun_o.
  - The current frame is abandoned with no last_o and no done_o.
  - Config is re-latched and the state restarts at SETTLE, or ACQ if settle_i==0, with ocnt=0.
  - chirp_start_i in DONE is the same as an overrun.
- **Simultaneous events**:
  - arm_i with chirp_start_i in IDLE: go to ARMED only; this chirp is missed.
  - arm_i in any non-IDLE state clears overrun_o and nothing else.
  - arm_i and an overrun condition in the same cycle: set wins.
- **Config changes**: settle_i/nsamp_i changes mid-chirp have no effect until the next latch.
- **Counters**: ocnt is NW bits and never wraps, because nreg ≤ 2^NW-1.

Decomposition:
- Shared package/defines (fmcw_defines): state encoding constants; OW/SW/NW defaults added to the common parameter set.
- One natural sub-module: chirp_acq_cnt, a loadable down-counter with terminal flag, instanced for settle and reused for the sample count.

Test Plan:
- Basic: arm_i, cont_i=0, settle_i=5, nsamp_i=4, chirp_start_i, downsampler decimating by 4 →
  - ACQ entered 5 cycles after ARMED sees chirp;
  - ds_clr_o one pulse;
  - exactly 4 valid_o, last_o on the 4th;
  - done_o one cycle later;
  - then IDLE with busy_o=0.
- Continuous: cont_i=1, three chirp_start_i spaced 200 cycles, nsamp_i=8 → 24 valid_o, 3 last_o, 3 done_o, overrun_o=0.
- Overrun: chirp_start_i again after 2 of 8 samples →
  - overrun_o=1, no last_o/done_o for frame 1;
  - frame 2 delivers 8 samples;
  - arm_i clears overrun_o.
- Edges:
  - settle_i=0 → ds_clr_o the cycle after chirp latch.
  - nsamp_i=0 → done_o with zero valid_o.
  - nsamp_i=1 → single valid_o with last_o.
- Reset mid-ACQ: drop rst_n_i after 3 samples → all outputs 0 immediately (async), state IDLE; chirp_start_i without arm_i produces nothing.
- Data integrity: ramp on ds_data_i → data_o equals ds_data_i sampled one cycle earlier on every valid_o.
